interlock_abc: RTL and testbench

Eight-station ring interlock (stations A–H) that grants exclusive access to at most one requesting station at a time. Each station drives a request and receives a registered grant, and every grant is fed back to all stations. The block arbitrates simultaneous requests round-robin around the ring and enforces a release gap between owners. It sits between the station request logic and the shared resource enable.

---
 rtl/interlock_abc_pkg.sv | 22 ++
 rtl/interlock_abc_cell.sv | 20 ++
 rtl/interlock_abc.sv | 100 ++++++++++
 tb/tb_interlock_abc.sv | 137 +++++++++++++
 4 files changed

// File: rtl/interlock_abc_pkg.sv
// Shared constants and ring-index helper for the eight-station interlock.
package interlock_abc_pkg;

    localparam int unsigned NUM_STATIONS = 8;
    localparam int unsigned IDX_W        = 3;

    typedef enum logic [IDX_W-1:0] {
        ST_A = 3'd0,
        ST_B = 3'd1,
        ST_C = 3'd2,
        ST_D = 3'd3,
        ST_E = 3'd4,
        ST_F = 3'd5,
        ST_G = 3'd6,
        ST_H = 3'd7
    } station_e;

    function automatic logic [IDX_W-1:0] next_station(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_STATIONS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/interlock_abc_cell.sv
// Per-station grant cell: computes the station's next grant from local and fed-back grants.
module interlock_cell
    import interlock_abc_pkg::*;
(
    input  logic                    req,
    input  logic                    own,
    input  logic [NUM_STATIONS-2:0] others,
    input  logic                    win,
    input  logic                    limit,
    output logic                    grant_next
);

    logic acquire;
    logic keep;

    assign acquire    = req & ~(|others) & win;
    assign keep       = own & req & ~limit;
    assign grant_next = acquire | keep;

endmodule

// File: rtl/interlock_abc.sv
// Eight-station ring interlock: round-robin grant with mandatory release gap and optional hold limit.
module interlock_abc
    import interlock_abc_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_A,
    input  logic i_B,
    input  logic i_C,
    input  logic i_D,
    input  logic i_E,
    input  logic i_F,
    input  logic i_G,
    input  logic i_H,
    output logic o_A,
    output logic o_B,
    output logic o_C,
    output logic o_D,
    output logic o_E,
    output logic o_F,
    output logic o_G,
    output logic o_H,
    output logic o_busy
);

    localparam int unsigned CW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

    logic [NUM_STATIONS-1:0] req;
    logic [NUM_STATIONS-1:0] g;
    logic [NUM_STATIONS-1:0] g_next;
    logic [NUM_STATIONS-1:0] win;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        ptr_next;
    logic [IDX_W-1:0]        idx;
    logic                    found;
    logic [CW-1:0]           hold_cnt;
    logic [CW-1:0]           hold_cnt_next;
    logic                    limit;

    assign req = {i_H, i_G, i_F, i_E, i_D, i_C, i_B, i_A};

    // Round-robin search from ptr+1; strobes are suppressed while any grant is held.
    always_comb begin
        win      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = next_station(ptr);
        for (int unsigned k = 0; k < NUM_STATIONS; k++) begin
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                ptr_next = idx;
                found    = 1'b1;
            end
            idx = next_station(idx);
        end
        if (g != '0) begin
            win      = '0;
            ptr_next = ptr;
        end
    end

    assign limit = (HOLD_MAX != 0) && (hold_cnt == HOLD_LIM);

    for (genvar i = 0; i < NUM_STATIONS; i++) begin : g_cell
        logic [NUM_STATIONS-2:0] others;
        for (genvar j = 0; j < NUM_STATIONS - 1; j++) begin : g_fb
            assign others[j] = g[(j < i) ? j : j + 1];
        end
        interlock_cell u_cell (
            .req        (req[i]),
            .own        (g[i]),
            .others     (others),
            .win        (win[i]),
            .limit      (limit),
            .grant_next (g_next[i])
        );
    end

    // hold_cnt is zero exactly when no grant is set, so it counts cycles of the current grant.
    assign hold_cnt_next = (g_next != '0) ? hold_cnt + CW'(1) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g        <= '0;
            ptr      <= ST_H;
            hold_cnt <= '0;
        end else begin
            g        <= g_next;
            ptr      <= ptr_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    assign {o_H, o_G, o_F, o_E, o_D, o_C, o_B, o_A} = g;
    assign o_busy = |g;

endmodule

// File: tb/tb_interlock_abc.sv
// Directed, table-driven bench for interlock_abc (unlimited hold and HOLD_MAX=3 instances).
module tb_interlock_abc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] req0 = '0;
    logic [7:0] req3 = '0;
    logic [7:0] g0, g3;
    logic busy0, busy3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    interlock_abc dut0 (
        .clk(clk), .rst(rst),
        .i_A(req0[0]), .i_B(req0[1]), .i_C(req0[2]), .i_D(req0[3]),
        .i_E(req0[4]), .i_F(req0[5]), .i_G(req0[6]), .i_H(req0[7]),
        .o_A(g0[0]), .o_B(g0[1]), .o_C(g0[2]), .o_D(g0[3]),
        .o_E(g0[4]), .o_F(g0[5]), .o_G(g0[6]), .o_H(g0[7]),
        .o_busy(busy0)
    );

    interlock_abc #(.HOLD_MAX(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_A(req3[0]), .i_B(req3[1]), .i_C(req3[2]), .i_D(req3[3]),
        .i_E(req3[4]), .i_F(req3[5]), .i_G(req3[6]), .i_H(req3[7]),
        .o_A(g3[0]), .o_B(g3[1]), .o_C(g3[2]), .o_D(g3[3]),
        .o_E(g3[4]), .o_F(g3[5]), .o_G(g3[6]), .o_H(g3[7]),
        .o_busy(busy3)
    );

    localparam logic [7:0] A = 8'h01, B = 8'h02, C = 8'h04, D = 8'h08;
    localparam logic [7:0] E = 8'h10, F = 8'h20, G = 8'h40, H = 8'h80;

    typedef struct {
        string      name;
        logic [7:0] req;
        logic [7:0] exp_g;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req0 = '0;
        req3 = '0;
        rst  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vecs.push_back('{"a_only",      A,             A});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{"lockout",  8'hFF,         A});
        vecs.push_back('{"rel_gap_c",   C | F,         8'h00});
        vecs.push_back('{"grant_c",     C | F,         C});
        vecs.push_back('{"rel_gap_f",   F,             8'h00});
        vecs.push_back('{"grant_f",     F,             F});
        vecs.push_back('{"rel_idle",    8'h00,         8'h00});
        vecs.push_back('{"idle",        8'h00,         8'h00});
        vecs.push_back('{"grant_h",     H,             H});
        vecs.push_back('{"wrap_gap",    A | G,         8'h00});
        vecs.push_back('{"wrap_a",      A | G,         A});
        vecs.push_back('{"rel_a",       8'h00,         8'h00});
        vecs.push_back('{"pulse_b",     B,             B});
        vecs.push_back('{"pulse_end",   8'h00,         8'h00});
        vecs.push_back('{"multi_idle",  B | D | E,     D});
        vecs.push_back('{"multi_rel",   8'h00,         8'h00});

        do_reset();
        check("reset_g0", g0, 8'h00);
        check("reset_busy0", {7'd0, busy0}, 8'h00);
        check("reset_g3", g3, 8'h00);

        foreach (vecs[k]) begin
            req0 = vecs[k].req;
            step();
            check(vecs[k].name, g0, vecs[k].exp_g);
            check({vecs[k].name, "_busy"}, {7'd0, busy0}, {7'd0, |vecs[k].exp_g});
        end

        // Hold limit: B alone gets 3 cycles, 1 gap, then re-granted; D present in gap wins.
        do_reset();
        req3 = B;
        for (int c = 0; c < 3; c++) begin
            step();
            check("hold_b1", g3, B);
        end
        step();
        check("hold_gap1", g3, 8'h00);
        for (int c = 0; c < 3; c++) begin
            step();
            check("hold_b2", g3, B);
        end
        req3 = B | D;
        step();
        check("hold_gap2", g3, 8'h00);
        step();
        check("hold_d_wins", g3, D);
        check("hold_busy", {7'd0, busy3}, 8'h01);

        // Asynchronous reset mid-grant, then ptr must be back at H.
        do_reset();
        req0 = E;
        step();
        check("async_e_grant", g0, E);
        #2;
        rst = 1'b1;
        #1;
        check("async_clear_g", g0, 8'h00);
        check("async_clear_busy", {7'd0, busy0}, 8'h00);
        rst  = 1'b0;
        req0 = A | E;
        step();
        check("async_a_wins", g0, A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
